multi_mode_ff_bank: RTL and testbench
=====================================

// Module: multi_mode_ff_bank
// PURPOSE
//  WIDTH-channel clocked flip-flop bank. Generalises the single SR latch stage into a
//  synchronous, parametrised bank with a selectable storage mode (SR/JK/D/T).
//  Per-channel sticky flags record illegal SR inputs; a saturating counter records
//  cycles on which any output changed. Used as the bistable storage element in the
//  lab datapath blocks.
// PARAMETERS
//  WIDTH        4   number of independent channels
//  RESET_VAL    0   WIDTH-bit value loaded into Q1 on reset
//  SR_CONFLICT  0   SR-mode response to S=R=1: 0 hold, 1 set-dominant, 2 reset-dominant
//  CNT_W        8   width of CHG_CNT
// PORTS
//  CLK      in   1        clock, all state updates on rising edge
//  RST_N    in   1        asynchronous active-low reset
//  EN       in   1        1 = update Q1 this cycle; 0 = hold all channels
//  MODE_WE  in   1        1 = load MODE into the mode register this cycle
//  MODE     in   2        00 SR, 01 JK, 10 D, 11 T
//  S        in   WIDTH    S / J / D / T input, per channel
//  R        in   WIDTH    R / K input, per channel (ignored in D and T modes)
//  ERR_CLR  in   1        clears ERR and CHG_CNT
//  Q1       out  WIDTH    stored state
//  Q2       out  WIDTH    always ~Q1 (combinational)
//  MODE_Q   out  2        current mode register
//  ERR      out  WIDTH    sticky flag: channel saw S=R=1 while EN=1 in SR mode
//  CHG_CNT  out  CNT_W    saturating count of cycles on which Q1 changed
// BEHAVIOUR
//  Reset (RST_N=0, async): Q1=RESET_VAL, Q2=~RESET_VAL, MODE_Q=00 (SR), ERR=0,
//   CHG_CNT=0. Outputs take these values immediately, not at the next edge.
//  Mode register: on an edge with MODE_WE=1, MODE_Q<=MODE. The new mode governs the
//   following edge onward. On an edge with MODE_WE=1 and EN=1, Q1 updates using the
//   old MODE_Q.
//  Next state per channel i, computed on the edge when EN=1, using MODE_Q:
//   SR: S=0,R=0 hold; 1,0 ->1; 0,1 ->0; 1,1 -> per SR_CONFLICT.
//   JK: 00 hold; 10 ->1; 01 ->0; 11 toggle.
//   D : Q<=S[i].   T: S[i]=1 toggle, else hold.
//   EN=0: Q1 holds in all modes. ERR and CHG_CNT are not updated.
//  Latency: one edge from input to Q1/Q2. Q2 is never equal to Q1 in any bit.
//  ERR[i]: set on the edge when MODE_Q=SR, EN=1 and S[i]=R[i]=1. Set happens for any
//   SR_CONFLICT value. ERR stays set until ERR_CLR or reset.
//  CHG_CNT: +1 on an edge where the next Q1 differs from the current Q1.
//   Saturates at 2^CNT_W-1 and never wraps.
//  ERR_CLR=1 on an edge: ERR<=0 and CHG_CNT<=0. Clear has priority over a
//   simultaneous set or increment on the same edge.
//  Reset asserted mid-operation overrides everything. Deassertion is used as-is and
//   is not synchronised inside the block; the parent is responsible for synchronising it.
//  Illegal SR_CONFLICT values (>2) behave as 0 (hold).
// TESTING
//  1 Reset: RST_N=0 between edges with Q1=4'hF -> Q1=0, Q2=4'hF, MODE_Q=0,
//    CHG_CNT=0 at once, before the next edge.
//  2 SR: EN=1, S=4'b0001, R=0 -> Q1=0001. Then S=0, R=0001 -> Q1=0000.
//    Then S=R=4'b0010 with SR_CONFLICT=0 -> Q1 held and ERR=0010.
//  3 SR_CONFLICT=1/2 builds: S=R=4'hF -> Q1=4'hF / 4'h0; ERR=4'hF in both builds.
//  4 JK: MODE_WE=1, MODE=01, then S=R=4'hF for 3 edges from Q1=0 ->
//    Q1 = F, 0, F; CHG_CNT=3.
//  5 D/T with EN toggling: MODE=10, S=4'hA, EN=0 -> Q1 unchanged, CHG_CNT unchanged.
//    Then EN=1 -> Q1=A. Then MODE=11, S=4'h3 -> Q1=9.
//  6 Counter and clear: CNT_W=2, 5 changing edges -> CHG_CNT=3 (saturated).
//    ERR_CLR together with an SR conflict -> ERR=0 and CHG_CNT=0 after the edge.

Source files
------------

// File: rtl/multi_mode_ff_bank.sv
// WIDTH-channel clocked flip-flop bank with selectable SR/JK/D/T storage mode,
// sticky per-channel SR-conflict flags and a saturating output-change counter.
module multi_mode_ff_bank #(
  parameter int unsigned      WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter int unsigned      SR_CONFLICT = 0,
  parameter int unsigned      CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             MODE_WE,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             ERR_CLR,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [1:0]       MODE_Q,
  output logic [WIDTH-1:0] ERR,
  output logic [CNT_W-1:0] CHG_CNT
);

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_t;

  mode_t            mode_q;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] conflict;
  logic [WIDTH-1:0] err_q;
  logic [CNT_W-1:0] cnt_q;
  logic             changed;

  // Next state always uses the registered mode, so a same-edge MODE_WE
  // only takes effect from the following edge.
  always_comb begin
    q_next   = q;
    conflict = '0;
    if (EN) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        case (mode_q)
          MODE_SR: begin
            if (S[i] && R[i]) begin
              conflict[i] = 1'b1;
              if (SR_CONFLICT == 1)      q_next[i] = 1'b1;
              else if (SR_CONFLICT == 2) q_next[i] = 1'b0;
            end else if (S[i]) begin
              q_next[i] = 1'b1;
            end else if (R[i]) begin
              q_next[i] = 1'b0;
            end
          end
          MODE_JK: begin
            if (S[i] && R[i]) q_next[i] = ~q[i];
            else if (S[i])    q_next[i] = 1'b1;
            else if (R[i])    q_next[i] = 1'b0;
          end
          MODE_D: q_next[i] = S[i];
          MODE_T: if (S[i]) q_next[i] = ~q[i];
          default: q_next[i] = q[i];
        endcase
      end
    end
    changed = (q_next != q);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q      <= RESET_VAL;
      mode_q <= MODE_SR;
      err_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (MODE_WE) mode_q <= mode_t'(MODE);
      if (EN)      q      <= q_next;
      if (ERR_CLR) begin
        err_q <= '0;
        cnt_q <= '0;
      end else if (EN) begin
        err_q <= err_q | conflict;
        if (changed && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign Q1      = q;
  assign Q2      = ~q;
  assign MODE_Q  = mode_q;
  assign ERR     = err_q;
  assign CHG_CNT = cnt_q;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Bench for multi_mode_ff_bank: three builds (hold / set-dominant / reset-dominant,
// the last with a 2-bit counter) checked every cycle against a characteristic-equation model.
module tb_multi_mode_ff_bank;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       EN = 1'b0;
  logic       MODE_WE = 1'b0;
  logic [1:0] MODE = 2'b00;
  logic [3:0] S = '0;
  logic [3:0] R = '0;
  logic       ERR_CLR = 1'b0;

  logic [3:0] q1_a [3];
  logic [3:0] q2_a [3];
  logic [1:0] mq_a [3];
  logic [3:0] err_a [3];
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  int unsigned errors = 0;
  int unsigned checks = 0;
  bit          run = 1'b0;

  multi_mode_ff_bank #(.WIDTH(4), .RESET_VAL(4'h0), .SR_CONFLICT(0), .CNT_W(8)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE_WE(MODE_WE), .MODE(MODE), .S(S), .R(R),
    .ERR_CLR(ERR_CLR), .Q1(q1_a[0]), .Q2(q2_a[0]), .MODE_Q(mq_a[0]), .ERR(err_a[0]),
    .CHG_CNT(cnt0));
  multi_mode_ff_bank #(.WIDTH(4), .RESET_VAL(4'h0), .SR_CONFLICT(1), .CNT_W(8)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE_WE(MODE_WE), .MODE(MODE), .S(S), .R(R),
    .ERR_CLR(ERR_CLR), .Q1(q1_a[1]), .Q2(q2_a[1]), .MODE_Q(mq_a[1]), .ERR(err_a[1]),
    .CHG_CNT(cnt1));
  multi_mode_ff_bank #(.WIDTH(4), .RESET_VAL(4'h0), .SR_CONFLICT(2), .CNT_W(2)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE_WE(MODE_WE), .MODE(MODE), .S(S), .R(R),
    .ERR_CLR(ERR_CLR), .Q1(q1_a[2]), .Q2(q2_a[2]), .MODE_Q(mq_a[2]), .ERR(err_a[2]),
    .CHG_CNT(cnt2));

  always #5 CLK = ~CLK;

  // Reference model: whole-vector characteristic equations per mode.
  int unsigned conf_of [3] = '{0, 1, 2};
  int unsigned cmax_of [3] = '{255, 255, 3};
  logic [3:0]  m_q   [3];
  logic [3:0]  m_err [3];
  int unsigned m_cnt [3];
  logic [1:0]  m_mode;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < 3; k++) begin
        m_q[k] = 4'h0; m_err[k] = 4'h0; m_cnt[k] = 0;
      end
      m_mode = 2'b00;
    end else begin
      for (int k = 0; k < 3; k++) begin
        logic [3:0] nq, c, v;
        nq = m_q[k];
        if (EN) begin
          case (m_mode)
            2'b00: begin
              c  = S & R;
              v  = (conf_of[k] == 1) ? 4'hF : (conf_of[k] == 2) ? 4'h0 : m_q[k];
              nq = (~c & (S | (m_q[k] & ~R))) | (c & v);
            end
            2'b01:   nq = (S & ~m_q[k]) | (~R & m_q[k]);
            2'b10:   nq = S;
            default: nq = m_q[k] ^ S;
          endcase
        end
        if (ERR_CLR) begin
          m_err[k] = 4'h0; m_cnt[k] = 0;
        end else if (EN) begin
          if (m_mode == 2'b00) m_err[k] = m_err[k] | (S & R);
          if (nq != m_q[k] && m_cnt[k] < cmax_of[k]) m_cnt[k] = m_cnt[k] + 1;
        end
        m_q[k] = nq;
      end
      if (MODE_WE) m_mode = MODE;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int k);
    case (k)
      0:       return {24'h0, cnt0};
      1:       return {24'h0, cnt1};
      default: return {30'h0, cnt2};
    endcase
  endfunction

  always @(negedge CLK) begin
    if (run) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("q1[%0d]", k),  {28'h0, q1_a[k]}, {28'h0, m_q[k]});
        check($sformatf("q2[%0d]", k),  {28'h0, q2_a[k]}, {28'h0, ~m_q[k]});
        check($sformatf("mode[%0d]", k), {30'h0, mq_a[k]}, {30'h0, m_mode});
        check($sformatf("err[%0d]", k), {28'h0, err_a[k]}, {28'h0, m_err[k]});
        check($sformatf("cnt[%0d]", k), cnt_of(k), m_cnt[k]);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic drive(input logic en, input logic we, input logic [1:0] md,
                       input logic [3:0] s, input logic [3:0] r, input logic clr);
    EN = en; MODE_WE = we; MODE = md; S = s; R = r; ERR_CLR = clr;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #2;
    RST_N = 1'b1;
    run = 1'b1;

    // Reach Q1=F in D mode, then pulse reset between edges
    drive(0, 1, 2'b10, 4'h0, 4'h0, 0); step();
    check("mode_d", {30'h0, mq_a[0]}, 32'h2);
    drive(1, 0, 2'b10, 4'hF, 4'h0, 0); step();
    check("d_f", {28'h0, q1_a[0]}, 32'hF);
    RST_N = 1'b0;
    #1;
    check("rst_q1",   {28'h0, q1_a[0]}, 32'h0);
    check("rst_q2",   {28'h0, q2_a[0]}, 32'hF);
    check("rst_mode", {30'h0, mq_a[0]}, 32'h0);
    check("rst_cnt",  cnt_of(0), 32'h0);
    #1;
    RST_N = 1'b1;

    // SR mode
    drive(1, 0, 2'b00, 4'h1, 4'h0, 0); step();
    check("sr_set", {28'h0, q1_a[0]}, 32'h1);
    drive(1, 0, 2'b00, 4'h0, 4'h1, 0); step();
    check("sr_rst", {28'h0, q1_a[0]}, 32'h0);
    drive(1, 0, 2'b00, 4'h2, 4'h2, 0); step();
    check("sr_hold_q",  {28'h0, q1_a[0]}, 32'h0);
    check("sr_hold_err", {28'h0, err_a[0]}, 32'h2);
    check("sr_setdom_q", {28'h0, q1_a[1]}, 32'h2);
    drive(1, 0, 2'b00, 4'hF, 4'hF, 0); step();
    check("conf1_q",   {28'h0, q1_a[1]}, 32'hF);
    check("conf2_q",   {28'h0, q1_a[2]}, 32'h0);
    check("conf1_err", {28'h0, err_a[1]}, 32'hF);
    check("conf2_err", {28'h0, err_a[2]}, 32'hF);

    // JK mode: clear Q1 and counters, then toggle three times
    drive(0, 1, 2'b01, 4'h0, 4'h0, 1); step();
    drive(1, 0, 2'b01, 4'h0, 4'hF, 0); step();
    drive(0, 0, 2'b01, 4'h0, 4'h0, 1); step();
    drive(1, 0, 2'b01, 4'hF, 4'hF, 0); step();
    check("jk_t1", {28'h0, q1_a[1]}, 32'hF);
    step();
    check("jk_t2", {28'h0, q1_a[1]}, 32'h0);
    step();
    check("jk_t3",  {28'h0, q1_a[0]}, 32'hF);
    check("jk_cnt", cnt_of(0), 32'h3);

    // D/T with EN toggling
    drive(0, 1, 2'b10, 4'hA, 4'h0, 0); step();
    check("en0_q",   {28'h0, q1_a[0]}, 32'hF);
    check("en0_cnt", cnt_of(0), 32'h3);
    drive(1, 0, 2'b10, 4'hA, 4'h0, 0); step();
    check("d_a", {28'h0, q1_a[0]}, 32'hA);
    drive(0, 1, 2'b11, 4'h3, 4'h0, 0); step();
    drive(1, 0, 2'b11, 4'h3, 4'h0, 0); step();
    check("t_9", {28'h0, q1_a[0]}, 32'h9);
    drive(1, 1, 2'b10, 4'h3, 4'h0, 0); step();
    check("oldmode_q",  {28'h0, q1_a[0]}, 32'hA);
    check("oldmode_mq", {30'h0, mq_a[0]}, 32'h2);
    drive(1, 0, 2'b10, 4'h5, 4'h0, 0); step();
    check("d_5", {28'h0, q1_a[0]}, 32'h5);

    // Counter saturation and clear priority
    drive(0, 0, 2'b10, 4'h5, 4'h0, 1); step();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 2'b10, (i % 2 == 0) ? 4'h0 : 4'hF, 4'h0, 0); step();
    end
    check("sat_cnt2", cnt_of(2), 32'h3);
    check("cnt0_5",   cnt_of(0), 32'h5);
    drive(0, 1, 2'b00, 4'h0, 4'h0, 0); step();
    drive(1, 0, 2'b00, 4'h2, 4'h2, 0); step();
    check("pre_clr_err", {28'h0, err_a[0]}, 32'h2);
    drive(1, 0, 2'b00, 4'h1, 4'h1, 1); step();
    check("clr_q1",   {28'h0, q1_a[1]}, 32'h3);
    check("clr_err",  {28'h0, err_a[1]}, 32'h0);
    check("clr_cnt1", cnt_of(1), 32'h0);
    check("clr_cnt2", cnt_of(2), 32'h0);
    drive(0, 0, 2'b00, 4'h0, 4'h0, 0); step();
    step();

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
